// File: rtl/game_state_ctrl.sv
// ============================================================================
// game_state_ctrl : Frogger game sequencer (MENU/PLAYING/DEAD/WIN), lives,
//                   round countdown, score and frog respawn pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module game_state_ctrl #(
  parameter int unsigned TICK_DIV      = 25_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned GRACE_CYCLES  = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_btn_i,
  input  logic       collision_i,
  input  logic       reached_end_i,
  output logic [1:0] state_o,
  output logic       frog_reset_o,
  output logic [2:0] lives_o,
  output logic [6:0] time_left_o,
  output logic [7:0] score_o,
  output logic       game_over_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = $clog2(GRACE_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_CYCLES);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
  localparam logic [6:0]    TIME_INIT  = 7'(ROUND_SECONDS);

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2,
    WIN     = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      lives_q, lives_d;
  logic [6:0]      time_q, time_d;
  logic [7:0]      score_q, score_d;
  logic            frog_reset_q, frog_reset_d;
  logic            game_over_q, game_over_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [GW-1:0]   grace_q, grace_d;
  logic            round_start;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= MENU;
      lives_q      <= LIVES_INIT;
      time_q       <= TIME_INIT;
      score_q      <= 8'd0;
      frog_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
      presc_q      <= '0;
      hold_q       <= '0;
      grace_q      <= '0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      time_q       <= time_d;
      score_q      <= score_d;
      frog_reset_q <= frog_reset_d;
      game_over_q  <= game_over_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      grace_q      <= grace_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    time_d       = time_q;
    score_d      = score_q;
    frog_reset_d = 1'b0;
    game_over_d  = game_over_q;
    presc_d      = presc_q;
    hold_d       = hold_q;
    grace_d      = grace_q;
    round_start  = 1'b0;

    case (state_q)
      MENU: begin
        if (start_btn_i) begin
          lives_d     = LIVES_INIT;
          score_d     = 8'd0;
          game_over_d = 1'b0;
          round_start = 1'b1;
        end
      end
      PLAYING: begin
        if (grace_q != '0) begin
          grace_d = grace_q - 1'b1;
        end
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        // Hazard/goal events win over the tick, so the countdown holds on those cycles.
        if (grace_q == '0 && reached_end_i) begin
          state_d = WIN;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          hold_d  = HOLD_INIT;
        end else if (grace_q == '0 && collision_i) begin
          state_d = DEAD;
          lives_d = lives_q - 3'd1;
          hold_d  = HOLD_INIT;
        end else if (presc_q == PRESC_MAX) begin
          time_d = time_q - 7'd1;
          if (time_q == 7'd1) begin
            state_d = DEAD;
            lives_d = lives_q - 3'd1;
            hold_d  = HOLD_INIT;
          end
        end
      end
      DEAD: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == '0) begin
          if (lives_q == 3'd0) begin
            state_d     = MENU;
            game_over_d = 1'b1;
          end else begin
            round_start = 1'b1;
          end
        end
      end
      WIN: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == '0) begin
          round_start = 1'b1;
        end
      end
      default: state_d = MENU;
    endcase

    if (round_start) begin
      state_d      = PLAYING;
      time_d       = TIME_INIT;
      presc_d      = '0;
      grace_d      = GRACE_INIT;
      frog_reset_d = 1'b1;
    end
  end

  assign state_o      = state_q;
  assign frog_reset_o = frog_reset_q;
  assign lives_o      = lives_q;
  assign time_left_o  = time_q;
  assign score_o      = score_q;
  assign game_over_o  = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
// ============================================================================
// tb_game_state_ctrl : directed + randomized bench against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_game_state_ctrl;

  localparam int TD = 4;
  localparam int HC = 3;
  localparam int SL = 2;
  localparam int RS = 3;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic       collision = 1'b0;
  logic       reached_end = 1'b0;
  logic [1:0] state;
  logic       frog_reset;
  logic [2:0] lives;
  logic [6:0] time_left;
  logic [7:0] score;
  logic       game_over;

  int total = 0;
  int bad = 0;

  // Behavioural model: k counts edges since entering the current state.
  int m_state, m_lives, m_time, m_score, m_fr, m_go, m_k;

  game_state_ctrl #(
    .TICK_DIV(TD), .HOLD_CYCLES(HC), .START_LIVES(SL),
    .ROUND_SECONDS(RS), .GRACE_CYCLES(GC)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_btn_i(start_btn),
    .collision_i(collision), .reached_end_i(reached_end),
    .state_o(state), .frog_reset_o(frog_reset), .lives_o(lives),
    .time_left_o(time_left), .score_o(score), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_round_start();
    m_state = 1;
    m_time  = RS;
    m_fr    = 1;
    m_k     = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      m_state = 0; m_lives = SL; m_time = RS; m_score = 0;
      m_fr = 0; m_go = 0; m_k = 0;
      return;
    end
    m_fr = 0;
    m_k++;
    case (m_state)
      0: if (start_btn) begin
        m_lives = SL; m_score = 0; m_go = 0;
        model_round_start();
      end
      1: begin
        if (m_k > GC && reached_end) begin
          m_state = 3; m_k = 0;
          if (m_score < 255) m_score++;
        end else if (m_k > GC && collision) begin
          m_state = 2; m_k = 0; m_lives--;
        end else if (m_k % TD == 0) begin
          m_time--;
          if (m_time == 0) begin
            m_state = 2; m_k = 0; m_lives--;
          end
        end
      end
      2: if (m_k == HC) begin
        if (m_lives == 0) begin
          m_state = 0; m_go = 1;
        end else begin
          model_round_start();
        end
      end
      default: if (m_k == HC) model_round_start();
    endcase
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_state);
    chk("frog_reset", int'(frog_reset), m_fr);
    chk("lives", int'(lives), m_lives);
    chk("time_left", int'(time_left), m_time);
    chk("score", int'(score), m_score);
    chk("game_over", int'(game_over), m_go);
  endtask

  // One clock: drive on the falling edge, advance model on the rising edge, compare 1 time unit later.
  task automatic step(input logic r, input logic s, input logic c, input logic e);
    @(negedge clk);
    reset = r; start_btn = s; collision = c; reached_end = e;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_state = 0; m_lives = SL; m_time = RS; m_score = 0;
    m_fr = 0; m_go = 0; m_k = 0;

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_state", int'(state), 0);
    chk("rst_lives", int'(lives), 2);
    chk("rst_time", int'(time_left), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_model_lives", m_lives, 2);

    // Events in MENU are ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_state", int'(state), 1);
    chk("start_fr", int'(frog_reset), 1);
    chk("start_model_fr", m_fr, 1);
    chk("start_time", int'(time_left), 3);

    // Held collision: two grace cycles, then DEAD.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fr_drop", int'(frog_reset), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("grace_state", int'(state), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("dead1_state", int'(state), 2);
    chk("dead1_lives", int'(lives), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("respawn_state", int'(state), 1);
    chk("respawn_fr", int'(frog_reset), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("dead2_lives", int'(lives), 0);
    idle(3);
    chk("over_state", int'(state), 0);
    chk("over_flag", int'(game_over), 1);
    chk("over_model_go", m_go, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_go", int'(game_over), 0);
    chk("restart_lives", int'(lives), 2);

    // Countdown to timeout.
    idle(4);
    chk("tick1_time", int'(time_left), 2);
    idle(4);
    chk("tick2_time", int'(time_left), 1);
    idle(4);
    chk("timeout_time", int'(time_left), 0);
    chk("timeout_state", int'(state), 2);
    chk("timeout_lives", int'(lives), 1);
    idle(3);

    // Simultaneous reached_end and collision after grace -> WIN.
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("win_state", int'(state), 3);
    chk("win_score", int'(score), 1);
    chk("win_lives", int'(lives), 1);
    idle(3);
    chk("win_exit_state", int'(state), 1);
    chk("win_exit_time", int'(time_left), 3);

    // Reset during DEAD.
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_state", int'(state), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dead_rst_state", int'(state), 0);
    chk("dead_rst_lives", int'(lives), 2);
    chk("dead_rst_score", int'(score), 0);
    chk("dead_rst_time", int'(time_left), 3);
    chk("dead_rst_fr", int'(frog_reset), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 13) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
